// File: rtl/icache_fill_ctrl_pkg.sv
// Shared geometry, FSM state encoding and address helpers for the icache line-fill controller.
package icache_fill_ctrl_pkg;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int BEATS      = 4;
   localparam int LINE_W     = BEATS * DATA_W;
   localparam int LINE_BYTES = LINE_W / 8;
   localparam int WORD_IDX_W = $clog2(BEATS);
   localparam int BYTE_OFF_W = $clog2(DATA_W / 8);
   localparam int LINE_OFF_W = $clog2(LINE_BYTES);
   localparam int TAG_W      = ADDR_W - LINE_OFF_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fill_state_t;

   function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [WORD_IDX_W-1:0] word);
      return {tag, word, {BYTE_OFF_W{1'b0}}};
   endfunction

   function automatic logic [ADDR_W-1:0] line_base(input logic [TAG_W-1:0] tag);
      return {tag, {LINE_OFF_W{1'b0}}};
   endfunction

endpackage

// File: rtl/icache_fill_ctrl_line_asm.sv
// Line assembly register: one DATA_W lane per word, written by word index as beats arrive.
module icache_fill_ctrl_line_asm
   import icache_fill_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [WORD_IDX_W-1:0] wr_idx,
   input  logic [DATA_W-1:0]     wr_data,
   output logic [LINE_W-1:0]     line
);

   logic [BEATS-1:0]  lane_we;
   logic [DATA_W-1:0] lanes [BEATS];

   for (genvar g = 0; g < BEATS; g++) begin : g_lane
      assign lane_we[g]                  = wr_en && (wr_idx == WORD_IDX_W'(g));
      assign line[g*DATA_W +: DATA_W]    = lanes[g];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < BEATS; i++) lanes[i] <= '0;
      end else begin
         for (int i = 0; i < BEATS; i++) begin
            if (lane_we[i]) lanes[i] <= wr_data;
         end
      end
   end

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache refill sequencer: fetches one line in single-word beats and writes it back with one pulse.
// Define FILL_CWF_EN for critical-word-first beat order and critical word forwarding.
module icache_fill_ctrl
   import icache_fill_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              miss_req,
   input  logic [ADDR_W-1:0] miss_addr,
   input  logic              miss_abort,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              fill_valid,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [LINE_W-1:0] fill_line,
   output logic              crit_valid,
   output logic [DATA_W-1:0] crit_word,
   output logic              busy
);

   fill_state_t           state, next_state;
   logic [TAG_W-1:0]      line_tag, line_tag_d;
   logic [WORD_IDX_W-1:0] word_idx, word_idx_d, next_word;
   logic [WORD_IDX_W-1:0] beat_cnt, beat_cnt_d;
   logic [WORD_IDX_W-1:0] start_word;
   logic                  accept, beat_ok, last_beat;
   logic                  mem_req_d, fill_valid_d, crit_valid_d, busy_d;
   logic [ADDR_W-1:0]     mem_addr_d, fill_addr_d;
   logic [DATA_W-1:0]     crit_word_d;

`ifdef FILL_CWF_EN
   logic unused_offset;
   assign unused_offset = &{1'b0, miss_addr[BYTE_OFF_W-1:0]};
   assign start_word    = miss_addr[LINE_OFF_W-1:BYTE_OFF_W];
`else
   logic unused_offset;
   assign unused_offset = &{1'b0, miss_addr[LINE_OFF_W-1:0]};
   assign start_word    = '0;
`endif

   // An abort on the same cycle as an ack closes the handshake, so that beat is dropped rather than stored.
   assign accept    = (state == ST_IDLE) && miss_req && !miss_abort;
   assign beat_ok   = (state == ST_BEAT) && mem_ack && !miss_abort;
   assign last_beat = (beat_cnt == WORD_IDX_W'(BEATS - 1));
   assign next_word = word_idx + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (accept) next_state = ST_BEAT;
         ST_BEAT: begin
            if (miss_abort)               next_state = mem_ack ? ST_IDLE : ST_DRAIN;
            else if (mem_ack && last_beat) next_state = ST_DONE;
         end
         ST_DRAIN: if (mem_ack) next_state = ST_IDLE;
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // A drained request stays asserted because the bus handshake cannot be withdrawn once raised.
   always_comb begin
      mem_req_d    = (next_state == ST_BEAT) || (next_state == ST_DRAIN);
      busy_d       = (next_state != ST_IDLE);
      fill_valid_d = (state == ST_DONE);
      fill_addr_d  = (state == ST_DONE) ? line_base(line_tag) : fill_addr;
      mem_addr_d   = mem_addr;
      line_tag_d   = line_tag;
      word_idx_d   = word_idx;
      beat_cnt_d   = beat_cnt;
      if (accept) begin
         line_tag_d = miss_addr[ADDR_W-1:LINE_OFF_W];
         word_idx_d = start_word;
         beat_cnt_d = '0;
         mem_addr_d = beat_addr(miss_addr[ADDR_W-1:LINE_OFF_W], start_word);
      end else if (beat_ok) begin
         word_idx_d = next_word;
         beat_cnt_d = beat_cnt + 1'b1;
         mem_addr_d = beat_addr(line_tag, next_word);
      end
`ifdef FILL_CWF_EN
      crit_valid_d = beat_ok && (beat_cnt == '0);
      crit_word_d  = (beat_ok && (beat_cnt == '0)) ? mem_rdata : crit_word;
`else
      crit_valid_d = 1'b0;
      crit_word_d  = '0;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         fill_valid <= 1'b0;
         fill_addr  <= '0;
         crit_valid <= 1'b0;
         crit_word  <= '0;
         busy       <= 1'b0;
         line_tag   <= '0;
         word_idx   <= '0;
         beat_cnt   <= '0;
      end else begin
         mem_req    <= mem_req_d;
         mem_addr   <= mem_addr_d;
         fill_valid <= fill_valid_d;
         fill_addr  <= fill_addr_d;
         crit_valid <= crit_valid_d;
         crit_word  <= crit_word_d;
         busy       <= busy_d;
         line_tag   <= line_tag_d;
         word_idx   <= word_idx_d;
         beat_cnt   <= beat_cnt_d;
      end
   end

   icache_fill_ctrl_line_asm u_line_asm (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (beat_ok),
      .wr_idx  (word_idx),
      .wr_data (mem_rdata),
      .line    (fill_line)
   );

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl: directed miss/stall/abort scenarios plus randomized traffic
// checked against a transaction-level model of the refill rules.
module tb_icache_fill_ctrl;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         miss_req = 1'b0;
   logic [31:0]  miss_addr = '0;
   logic         miss_abort = 1'b0;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic         mem_ack = 1'b0;
   logic [31:0]  mem_rdata = '0;
   logic         fill_valid;
   logic [31:0]  fill_addr;
   logic [127:0] fill_line;
   logic         crit_valid;
   logic [31:0]  crit_word;
   logic         busy;

   int total = 0;
   int bad   = 0;
   bit cwf;

   // Reference model: expected outputs as seen after the next rising edge.
   bit           fetching, draining, fill_due;
   int           beats_got, m_w0;
   logic [31:0]  m_line;
   logic [31:0]  m_words [4];
   logic         exp_mem_req, exp_fill_valid, exp_crit_valid, exp_busy;
   logic [31:0]  exp_mem_addr, exp_fill_addr, exp_crit_word;
   logic [127:0] exp_fill_line;

   icache_fill_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .miss_req   (miss_req),
      .miss_addr  (miss_addr),
      .miss_abort (miss_abort),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .fill_valid (fill_valid),
      .fill_addr  (fill_addr),
      .fill_line  (fill_line),
      .crit_valid (crit_valid),
      .crit_word  (crit_word),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic model_reset;
      fetching = 0; draining = 0; fill_due = 0; beats_got = 0; m_w0 = 0; m_line = '0;
      for (int i = 0; i < 4; i++) m_words[i] = '0;
      exp_mem_req = 0; exp_fill_valid = 0; exp_crit_valid = 0; exp_busy = 0;
      exp_mem_addr = '0; exp_fill_addr = '0; exp_crit_word = '0; exp_fill_line = '0;
   endtask

   task automatic model_step(input bit req, input bit abort, input bit ack,
                             input logic [31:0] addr, input logic [31:0] rdata);
      bit nf, ncv;
      int slot;
      nf = 0; ncv = 0;
      if (fill_due) begin
         nf = 1; fill_due = 0; exp_fill_addr = m_line;
         for (int i = 0; i < 4; i++) exp_fill_line[32*i +: 32] = m_words[i];
      end else if (draining) begin
         if (ack) begin draining = 0; exp_mem_req = 0; end
      end else if (fetching) begin
         if (abort) begin
            fetching = 0;
            if (ack) exp_mem_req = 0;
            else     draining = 1;
         end else if (ack) begin
            slot = (m_w0 + beats_got) % 4;
            m_words[slot] = rdata;
            if (beats_got == 0 && cwf) begin ncv = 1; exp_crit_word = rdata; end
            beats_got++;
            if (beats_got == 4) begin fetching = 0; fill_due = 1; exp_mem_req = 0; end
            else exp_mem_addr = m_line + 32'(4 * ((m_w0 + beats_got) % 4));
         end
      end else if (req && !abort) begin
         m_line = addr & 32'hFFFF_FFF0;
         m_w0 = cwf ? int'(addr[3:2]) : 0;
         beats_got = 0; fetching = 1; exp_mem_req = 1;
         exp_mem_addr = m_line + 32'(4 * m_w0);
      end
      exp_fill_valid = nf; exp_crit_valid = ncv;
      exp_busy = fetching || draining || fill_due;
   endtask

   // Drive one cycle of inputs at the falling edge and advance to the next falling edge.
   task automatic tick(input bit req, input bit abort, input bit ack,
                       input logic [31:0] addr, input logic [31:0] rdata);
      miss_req = req; miss_abort = abort; mem_ack = ack; miss_addr = addr; mem_rdata = rdata;
      model_step(req, abort, ack, addr, rdata);
      @(negedge clk);
   endtask

   task automatic settle;
      for (int n = 0; n < 10 && exp_busy; n++) tick(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      total++; if (mem_req !== 1'b0)      begin bad++; $display("[TB] FAIL reset_mem_req got=%0h want=0", mem_req); end
      total++; if (mem_addr !== 32'h0)    begin bad++; $display("[TB] FAIL reset_mem_addr got=%0h want=0", mem_addr); end
      total++; if (fill_valid !== 1'b0)   begin bad++; $display("[TB] FAIL reset_fill_valid got=%0h want=0", fill_valid); end
      total++; if (fill_addr !== 32'h0)   begin bad++; $display("[TB] FAIL reset_fill_addr got=%0h want=0", fill_addr); end
      total++; if (fill_line !== 128'h0)  begin bad++; $display("[TB] FAIL reset_fill_line got=%0h want=0", fill_line); end
      total++; if (crit_valid !== 1'b0)   begin bad++; $display("[TB] FAIL reset_crit_valid got=%0h want=0", crit_valid); end
      total++; if (crit_word !== 32'h0)   begin bad++; $display("[TB] FAIL reset_crit_word got=%0h want=0", crit_word); end
      total++; if (busy !== 1'b0)         begin bad++; $display("[TB] FAIL reset_busy got=%0h want=0", busy); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed;
      int w0, pulses, seen_at;
      logic [31:0]  want_a, got_addr, want_cw;
      logic [127:0] want_line, got_line;
      w0 = cwf ? 1 : 0; pulses = 0; seen_at = -1;
      got_addr = '0; got_line = '0; want_line = '0;
      tick(1'b1, 1'b0, 1'b0, 32'h0000_1004, 32'h0);
      for (int i = 0; i < 4; i++) begin
         want_a = 32'h1000 + 32'(4 * ((w0 + i) % 4));
         total++;
         if (mem_req !== 1'b1 || mem_addr !== want_a) begin
            bad++; $display("[TB] FAIL dir_beat%0d req/addr got=%0b/%0h want=1/%0h", i, mem_req, mem_addr, want_a);
         end
         want_line[32*((w0 + i) % 4) +: 32] = 32'hA0 + 32'(i);
         tick(1'b0, 1'b0, 1'b1, 32'h0, 32'hA0 + 32'(i));
         if (i == 0) begin
            want_cw = cwf ? 32'hA0 : 32'h0;
            total++;
            if (crit_valid !== cwf || crit_word !== want_cw) begin
               bad++; $display("[TB] FAIL dir_crit got=%0b/%0h want=%0b/%0h", crit_valid, crit_word, cwf, want_cw);
            end
         end
      end
      for (int k = 6; k <= 9; k++) begin
         tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         if (fill_valid === 1'b1) begin
            pulses++;
            if (seen_at < 0) begin seen_at = k; got_addr = fill_addr; got_line = fill_line; end
         end
      end
      total++; if (seen_at != 6)          begin bad++; $display("[TB] FAIL dir_latency got=%0d want=6", seen_at); end
      total++; if (pulses != 1)           begin bad++; $display("[TB] FAIL dir_pulses got=%0d want=1", pulses); end
      total++; if (got_addr !== 32'h1000) begin bad++; $display("[TB] FAIL dir_fill_addr got=%0h want=1000", got_addr); end
      total++; if (got_line !== want_line) begin bad++; $display("[TB] FAIL dir_fill_line got=%0h want=%0h", got_line, want_line); end
   endtask

`ifdef FILL_CWF_EN
   task automatic test_cwf;
      logic [31:0] want_a;
      tick(1'b1, 1'b0, 1'b0, 32'h0000_1008, 32'h0);
      for (int i = 0; i < 4; i++) begin
         want_a = 32'h1000 + 32'(4 * ((2 + i) % 4));
         total++;
         if (mem_req !== 1'b1 || mem_addr !== want_a) begin
            bad++; $display("[TB] FAIL cwf_beat%0d req/addr got=%0b/%0h want=1/%0h", i, mem_req, mem_addr, want_a);
         end
         tick(1'b0, 1'b0, 1'b1, 32'h0, 32'hB0 + 32'(i));
         if (i == 0) begin
            total++;
            if (crit_valid !== 1'b1 || crit_word !== 32'hB0) begin
               bad++; $display("[TB] FAIL cwf_crit got=%0b/%0h want=1/b0", crit_valid, crit_word);
            end
         end
      end
      tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      total++;
      if (fill_valid !== 1'b1 || fill_line[95:64] !== 32'hB0) begin
         bad++; $display("[TB] FAIL cwf_word2 got=%0b/%0h want=1/b0", fill_valid, fill_line[95:64]);
      end
      tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask
`endif

   task automatic test_stall;
      int pulses;
      logic [31:0] want_a;
      pulses = 0;
      tick(1'b1, 1'b0, 1'b0, 32'h0000_2340, 32'h0);
      for (int i = 0; i < 4; i++) begin
         want_a = 32'h2340 + 32'(4 * i);
         for (int s = 0; s < 4; s++) begin
            total++;
            if (mem_req !== 1'b1 || mem_addr !== want_a) begin
               bad++; $display("[TB] FAIL stall_b%0d_s%0d req/addr got=%0b/%0h want=1/%0h", i, s, mem_req, mem_addr, want_a);
            end
            tick(1'b0, 1'b0, (s == 3), 32'h0, $urandom);
         end
      end
      for (int k = 0; k < 4; k++) begin
         tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         if (fill_valid === 1'b1) pulses++;
      end
      total++; if (pulses != 1)   begin bad++; $display("[TB] FAIL stall_pulses got=%0d want=1", pulses); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL stall_busy_end got=%0b want=0", busy); end
   endtask

   task automatic test_abort_drain;
      int pulses;
      pulses = 0;
      tick(1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0);
      tick(1'b0, 1'b0, 1'b1, 32'h0, 32'h11);
      tick(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      for (int s = 0; s < 3; s++) begin
         total++;
         if (busy !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h3004) begin
            bad++; $display("[TB] FAIL drain_hold%0d busy/req/addr got=%0b/%0b/%0h want=1/1/3004", s, busy, mem_req, mem_addr);
         end
         if (fill_valid === 1'b1) pulses++;
         if (s < 2) tick(1'b1, 1'b0, 1'b0, 32'h0000_7770, 32'h0);
      end
      tick(1'b0, 1'b0, 1'b1, 32'h0, 32'h22);
      total++;
      if (mem_req !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("[TB] FAIL drain_exit req/busy got=%0b/%0b want=0/0", mem_req, busy);
      end
      for (int k = 0; k < 4; k++) begin
         tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         if (fill_valid === 1'b1) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("[TB] FAIL drain_no_fill got=%0d want=0", pulses); end
   endtask

   task automatic test_abort_with_ack;
      int pulses;
      logic [31:0]  got_addr;
      logic [127:0] want_line, got_line;
      pulses = 0; got_addr = '0; got_line = '0; want_line = '0;
      tick(1'b1, 1'b0, 1'b0, 32'h0000_4000, 32'h0);
      tick(1'b0, 1'b0, 1'b1, 32'h0, 32'h1);
      tick(1'b0, 1'b0, 1'b1, 32'h0, 32'h2);
      tick(1'b0, 1'b1, 1'b1, 32'h0, 32'h3);
      total++;
      if (busy !== 1'b0 || mem_req !== 1'b0 || fill_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL abort_ack_idle busy/req/fv got=%0b/%0b/%0b want=0/0/0", busy, mem_req, fill_valid);
      end
      tick(1'b1, 1'b0, 1'b0, 32'h0000_5550, 32'h0);
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h5550) begin
         bad++; $display("[TB] FAIL abort_ack_restart req/addr got=%0b/%0h want=1/5550", mem_req, mem_addr);
      end
      for (int i = 0; i < 4; i++) begin
         want_line[32*i +: 32] = 32'hC0 + 32'(i);
         tick(1'b0, 1'b0, 1'b1, 32'h0, 32'hC0 + 32'(i));
         if (fill_valid === 1'b1) pulses++;
      end
      for (int k = 0; k < 4; k++) begin
         tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         if (fill_valid === 1'b1) begin
            pulses++; got_addr = fill_addr; got_line = fill_line;
         end
      end
      total++; if (pulses != 1)            begin bad++; $display("[TB] FAIL abort_ack_pulses got=%0d want=1", pulses); end
      total++; if (got_addr !== 32'h5550)  begin bad++; $display("[TB] FAIL abort_ack_fill_addr got=%0h want=5550", got_addr); end
      total++; if (got_line !== want_line) begin bad++; $display("[TB] FAIL abort_ack_fill_line got=%0h want=%0h", got_line, want_line); end
   endtask

   task automatic test_random;
      bit req, abort, ack;
      for (int n = 0; n < 3000; n++) begin
         req   = 1'($urandom_range(0, 1));
         abort = ($urandom_range(0, 9) == 0);
         ack   = ($urandom_range(0, 9) < 6);
         tick(req, abort, ack, $urandom, $urandom);
         total++; if (mem_req !== exp_mem_req)       begin bad++; $display("[TB] FAIL rnd_mem_req cyc=%0d got=%0b want=%0b", n, mem_req, exp_mem_req); end
         total++; if (busy !== exp_busy)             begin bad++; $display("[TB] FAIL rnd_busy cyc=%0d got=%0b want=%0b", n, busy, exp_busy); end
         total++; if (fill_valid !== exp_fill_valid) begin bad++; $display("[TB] FAIL rnd_fill_valid cyc=%0d got=%0b want=%0b", n, fill_valid, exp_fill_valid); end
         total++; if (fill_addr !== exp_fill_addr)   begin bad++; $display("[TB] FAIL rnd_fill_addr cyc=%0d got=%0h want=%0h", n, fill_addr, exp_fill_addr); end
         total++; if (crit_valid !== exp_crit_valid) begin bad++; $display("[TB] FAIL rnd_crit_valid cyc=%0d got=%0b want=%0b", n, crit_valid, exp_crit_valid); end
         total++; if (crit_word !== exp_crit_word)   begin bad++; $display("[TB] FAIL rnd_crit_word cyc=%0d got=%0h want=%0h", n, crit_word, exp_crit_word); end
         if (exp_mem_req) begin
            total++; if (mem_addr !== exp_mem_addr)  begin bad++; $display("[TB] FAIL rnd_mem_addr cyc=%0d got=%0h want=%0h", n, mem_addr, exp_mem_addr); end
         end
         if (exp_fill_valid) begin
            total++; if (fill_line !== exp_fill_line) begin bad++; $display("[TB] FAIL rnd_fill_line cyc=%0d got=%0h want=%0h", n, fill_line, exp_fill_line); end
         end
      end
      settle();
   endtask

   task automatic test_async_reset;
      tick(1'b1, 1'b0, 1'b0, 32'h0000_6004, 32'h0);
      tick(1'b0, 1'b0, 1'b1, 32'h0, 32'hDD);
      #3 reset_n = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0)     begin bad++; $display("[TB] FAIL areset_mem_req got=%0h want=0", mem_req); end
      total++; if (mem_addr !== 32'h0)   begin bad++; $display("[TB] FAIL areset_mem_addr got=%0h want=0", mem_addr); end
      total++; if (fill_valid !== 1'b0)  begin bad++; $display("[TB] FAIL areset_fill_valid got=%0h want=0", fill_valid); end
      total++; if (fill_addr !== 32'h0)  begin bad++; $display("[TB] FAIL areset_fill_addr got=%0h want=0", fill_addr); end
      total++; if (fill_line !== 128'h0) begin bad++; $display("[TB] FAIL areset_fill_line got=%0h want=0", fill_line); end
      total++; if (crit_valid !== 1'b0)  begin bad++; $display("[TB] FAIL areset_crit_valid got=%0h want=0", crit_valid); end
      total++; if (crit_word !== 32'h0)  begin bad++; $display("[TB] FAIL areset_crit_word got=%0h want=0", crit_word); end
      total++; if (busy !== 1'b0)        begin bad++; $display("[TB] FAIL areset_busy got=%0h want=0", busy); end
      @(negedge clk);
      model_reset();
      reset_n = 1'b1;
      tick(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      total++;
      if (busy !== 1'b0 || mem_req !== 1'b0) begin
         bad++; $display("[TB] FAIL areset_after busy/req got=%0b/%0b want=0/0", busy, mem_req);
      end
   endtask

   initial begin
`ifdef FILL_CWF_EN
      cwf = 1'b1;
`else
      cwf = 1'b0;
`endif
      $display("[TB] starting icache_fill_ctrl bench, cwf=%0b", cwf);
      test_reset();
      test_directed();
`ifdef FILL_CWF_EN
      test_cwf();
`endif
      test_stall();
      test_abort_drain();
      test_abort_with_ack();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
